vga_scanout: RTL and testbench
==============================

VGA_SCANOUT -- requirements
Module: vga_scanout

Interface
REQ-001 Parameter START_LEVEL, 256, minimum FIFO fill (rdusedw) required before pixel output starts.
REQ-002 Parameter H_VIS/H_FP/H_SYNC/H_BP, 640/16/96/48, horizontal timing in clocks (total 800).
REQ-003 Parameter V_VIS/V_FP/V_SYNC/V_BP, 480/10/2/33, vertical timing in lines (total 525).
REQ-004 clock  input  1  pixel clock; all logic on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 q  input  24  FIFO read data, valid the cycle after rdreq (non-showahead); [23:16] red, [15:8] green, [7:0] blue.
REQ-007 rdempty  input  1  FIFO empty flag.
REQ-008 rdusedw  input  10  FIFO words available to read.
REQ-009 rdreq  output  1  FIFO read request, one word per asserted cycle.
REQ-010 hsync, vsync  output  1 each  sync pulses, active-low.
REQ-011 blank_n  output  1  high while the output pixel is in the visible area.
REQ-012 red, green, blue  output  8 each  pixel colour.
REQ-013 frame_start  output  1  one-cycle pulse coincident with output of pixel (0,0).
REQ-014 underflow  output  1  sticky flag: a visible pixel found the FIFO empty.

Function
REQ-015 h_cnt SHALL count 0..799 and wrap to 0; v_cnt SHALL increment when h_cnt wraps, count 0..524, wrap to 0.
REQ-016 Counters and sync generation SHALL run continuously in every state.
REQ-017 Raw hsync SHALL be low for h_cnt 656..751; raw vsync low for v_cnt 490..491; raw visible = h_cnt<640 && v_cnt<480.
REQ-018 FSM states: WAIT_FILL, RUN.
REQ-019 WAIT_FILL -> RUN SHALL occur only on the cycle where h_cnt==799, v_cnt==524 and rdusedw>=START_LEVEL; otherwise remain.
REQ-020 RUN SHALL persist until reset; underflow SHALL NOT leave RUN.
REQ-021 rdreq SHALL be (state==RUN) && raw visible && !rdempty, combinationally from registered state/counters.
REQ-022 Exactly 640 reads per line and 307200 per frame SHALL be issued when the FIFO never empties.
REQ-023 hsync, vsync, blank_n, frame_start SHALL be delayed one register stage so they align with q.
REQ-024 red/green/blue SHALL equal q fields when the delayed stage is visible, in RUN, and a read was issued; else 0.
REQ-025 Visible pixel in RUN with rdempty=1: no read, that pixel output 0, underflow set to 1; next pixel proceeds normally.
REQ-026 In WAIT_FILL rdreq SHALL stay 0, RGB 0, blank_n still follows timing.
REQ-027 Total output latency from counter position to pins SHALL be exactly one clock.

Reset
REQ-028 On reset: h_cnt=0, v_cnt=0, state=WAIT_FILL, hsync=1, vsync=1, blank_n=0, RGB=0, frame_start=0, underflow=0, rdreq=0.
REQ-029 Reset mid-frame SHALL take effect immediately (asynchronous); after release timing restarts at (0,0) in WAIT_FILL.
REQ-030 underflow SHALL be cleared only by reset.

Structure
REQ-031 Package vga_pkg SHALL hold timing constants (640x480@60 defaults) and state_t typedef, shared with the FIFO writer.
REQ-032 Sub-module vga_timing SHALL contain h/v counters and raw hsync/vsync/visible generation.

Verification
REQ-033 Reset, FIFO empty (rdusedw=0) -> hsync low 96 of every 800 clocks, vsync low 2 of every 525 lines, rdreq never 1, RGB 0.
REQ-034 rdusedw raised to 300 at (h=200,v=100) -> first rdreq at (0,0) of next frame; 640 reads/line, 307200/frame.
REQ-035 rdreq at (0,0), q=24'hA1B2C3 next cycle -> same cycle red=A1, green=B2, blue=C3, blank_n=1, frame_start=1.
REQ-036 rdempty=1 at (h=100,v=10) in RUN -> rdreq=0, that pixel RGB=0, underflow=1 thereafter; pixel 101 normal.
REQ-037 Reset asserted at (h=300,v=200) -> outputs go to reset values same cycle; after release WAIT_FILL, counters from 0.
REQ-038 h_cnt 640..799 in RUN -> rdreq=0, blank_n=0, RGB=0 (delayed one clock).

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA timing constants, scan-out state type and small timing helpers.
// Also imported by the FIFO writer side, so keep it free of scan-out internals.
package vga_pkg;

   // 640x480 @ 60 Hz defaults (pixel clock 25.175 MHz)
   localparam int H_VIS_DEF       = 640;
   localparam int H_FP_DEF        = 16;
   localparam int H_SYNC_DEF      = 96;
   localparam int H_BP_DEF        = 48;
   localparam int V_VIS_DEF       = 480;
   localparam int V_FP_DEF        = 10;
   localparam int V_SYNC_DEF      = 2;
   localparam int V_BP_DEF        = 33;
   localparam int START_LEVEL_DEF = 256;

   // Counter width covers 800 clocks per line and 525 lines per frame
   localparam int CNT_W   = 10;
   // Width of the FIFO fill-level port
   localparam int USEDW_W = 10;

   typedef enum logic [0:0] {
      WAIT_FILL = 1'b0,
      RUN       = 1'b1
   } state_t;

   // Undelayed timing derived straight from the counters
   typedef struct packed {
      logic hsync;    // active-low
      logic vsync;    // active-low
      logic visible;  // inside the active picture
      logic origin;   // counters sit at pixel (0,0)
   } timing_t;

   // True when cnt lies in the inclusive window [lo, hi]
   function automatic logic in_range(input logic [CNT_W-1:0] cnt,
                                     input int lo,
                                     input int hi);
      return (cnt >= CNT_W'(lo)) && (cnt <= CNT_W'(hi));
   endfunction

endpackage

// File: rtl/vga_timing.sv
// Free-running horizontal/vertical counters and raw (undelayed) sync,
// visible-area and origin flags. Runs in every scan-out state.
module vga_timing
   import vga_pkg::*;
#(
   parameter int H_VIS  = H_VIS_DEF,
   parameter int H_FP   = H_FP_DEF,
   parameter int H_SYNC = H_SYNC_DEF,
   parameter int H_BP   = H_BP_DEF,
   parameter int V_VIS  = V_VIS_DEF,
   parameter int V_FP   = V_FP_DEF,
   parameter int V_SYNC = V_SYNC_DEF,
   parameter int V_BP   = V_BP_DEF
)(
   input  logic    clock,
   input  logic    reset,
   output timing_t raw_o,
   output logic    frame_end_o
);

   localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

   logic [CNT_W-1:0] h_cnt_q;
   logic [CNT_W-1:0] h_cnt_d;
   logic [CNT_W-1:0] v_cnt_q;
   logic [CNT_W-1:0] v_cnt_d;
   logic             h_last_s;
   logic             v_last_s;

   assign h_last_s = (h_cnt_q == CNT_W'(H_TOTAL - 1));
   assign v_last_s = (v_cnt_q == CNT_W'(V_TOTAL - 1));

   // Next count: h wraps at end of line, v advances once per h wrap
   always_comb begin
      h_cnt_d = h_cnt_q;
      v_cnt_d = v_cnt_q;
      if (h_last_s) begin
         h_cnt_d = '0;
         if (v_last_s) begin
            v_cnt_d = '0;
         end else begin
            v_cnt_d = v_cnt_q + CNT_W'(1);
         end
      end else begin
         h_cnt_d = h_cnt_q + CNT_W'(1);
      end
   end

   // Counter registers, restart at (0,0) on reset
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         h_cnt_q <= '0;
         v_cnt_q <= '0;
      end else begin
         h_cnt_q <= h_cnt_d;
         v_cnt_q <= v_cnt_d;
      end
   end

   assign raw_o.hsync   = !in_range(h_cnt_q, H_VIS + H_FP, H_VIS + H_FP + H_SYNC - 1);
   assign raw_o.vsync   = !in_range(v_cnt_q, V_VIS + V_FP, V_VIS + V_FP + V_SYNC - 1);
   assign raw_o.visible = (h_cnt_q < CNT_W'(H_VIS)) && (v_cnt_q < CNT_W'(V_VIS));
   assign raw_o.origin  = (h_cnt_q == '0) && (v_cnt_q == '0);
   assign frame_end_o   = h_last_s && v_last_s;

endmodule

// File: rtl/vga_scanout.sv
// VGA scan-out: pulls pixels from a non-showahead FIFO and drives the pins.
// Reads start only at a frame boundary once the FIFO holds START_LEVEL words;
// all pin outputs trail the counters by exactly one clock so they line up
// with the FIFO read data.
module vga_scanout
   import vga_pkg::*;
#(
   parameter int START_LEVEL = START_LEVEL_DEF,
   parameter int H_VIS       = H_VIS_DEF,
   parameter int H_FP        = H_FP_DEF,
   parameter int H_SYNC      = H_SYNC_DEF,
   parameter int H_BP        = H_BP_DEF,
   parameter int V_VIS       = V_VIS_DEF,
   parameter int V_FP        = V_FP_DEF,
   parameter int V_SYNC      = V_SYNC_DEF,
   parameter int V_BP        = V_BP_DEF
)(
   input  logic               clock,
   input  logic               reset,
   input  logic [23:0]        q,
   input  logic               rdempty,
   input  logic [USEDW_W-1:0] rdusedw,
   output logic               rdreq,
   output logic               hsync,
   output logic               vsync,
   output logic               blank_n,
   output logic [7:0]         red,
   output logic [7:0]         green,
   output logic [7:0]         blue,
   output logic               frame_start,
   output logic               underflow
);

   timing_t raw_s;
   logic    frame_end_s;
   logic    fill_ok_s;
   logic    rdreq_s;
   state_t  state_q;
   logic    underflow_q;
   logic    hsync_q;
   logic    vsync_q;
   logic    blank_n_q;
   logic    frame_start_q;
   logic    rd_q;

   vga_timing #(
      .H_VIS  (H_VIS),
      .H_FP   (H_FP),
      .H_SYNC (H_SYNC),
      .H_BP   (H_BP),
      .V_VIS  (V_VIS),
      .V_FP   (V_FP),
      .V_SYNC (V_SYNC),
      .V_BP   (V_BP)
   ) u_timing (
      .clock       (clock),
      .reset       (reset),
      .raw_o       (raw_s),
      .frame_end_o (frame_end_s)
   );

   assign fill_ok_s = (rdusedw >= USEDW_W'(START_LEVEL));

   // A read is issued only for a visible pixel in RUN with data available;
   // an empty FIFO just skips that pixel.
   assign rdreq_s = (state_q == RUN) && raw_s.visible && !rdempty;
   assign rdreq   = rdreq_s;

   // Scan-out FSM: wait for a primed FIFO at the last pixel of a frame, then
   // stay in RUN until reset; underflow latches until reset.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= WAIT_FILL;
         underflow_q <= 1'b0;
      end else begin
         case (state_q)
            WAIT_FILL: begin
               if (frame_end_s && fill_ok_s) begin
                  state_q <= RUN;
               end else begin
                  state_q <= WAIT_FILL;
               end
            end
            RUN:     state_q <= RUN;
            default: state_q <= WAIT_FILL;
         endcase
         if ((state_q == RUN) && raw_s.visible && rdempty) begin
            underflow_q <= 1'b1;
         end else begin
            underflow_q <= underflow_q;
         end
      end
   end

   // One-clock delay stage so sync/blank/frame_start line up with q
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         hsync_q       <= 1'b1;
         vsync_q       <= 1'b1;
         blank_n_q     <= 1'b0;
         frame_start_q <= 1'b0;
         rd_q          <= 1'b0;
      end else begin
         hsync_q       <= raw_s.hsync;
         vsync_q       <= raw_s.vsync;
         blank_n_q     <= raw_s.visible;
         frame_start_q <= raw_s.origin;
         rd_q          <= rdreq_s;
      end
   end

   // Colour passes through only when last cycle's read delivered q;
   // skipped, blanked and pre-RUN pixels are black.
   always_comb begin
      if (rd_q) begin
         red   = q[23:16];
         green = q[15:8];
         blue  = q[7:0];
      end else begin
         red   = 8'd0;
         green = 8'd0;
         blue  = 8'd0;
      end
   end

   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign blank_n     = blank_n_q;
   assign frame_start = frame_start_q;
   assign underflow   = underflow_q;

endmodule

// File: tb/tb_vga_scanout.sv
// Scoreboard bench for vga_scanout using a shrunken raster (25x10 clocks).
// The stimulus process runs an independent raster model and pushes the
// expected pin values for each cycle; a monitor pops and compares them.
`timescale 1ns/1ps
module tb_vga_scanout;

   // Hand-chosen small timing: line = 16+2+4+3 = 25 clocks, frame = 6+1+2+1 = 10 lines
   localparam int HV = 16, HF = 2, HS = 4, HB = 3, HT = 25;
   localparam int VV = 6,  VF = 1, VS = 2, VB = 1, VT = 10;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [23:0] q = 24'd0;
   logic        rdempty = 1'b1;
   logic [9:0]  rdusedw = 10'd0;
   logic        rdreq, hsync, vsync, blank_n, frame_start, underflow;
   logic [7:0]  red, green, blue;

   vga_scanout #(
      .START_LEVEL (256),
      .H_VIS (HV), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
      .V_VIS (VV), .V_FP (VF), .V_SYNC (VS), .V_BP (VB)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .q           (q),
      .rdempty     (rdempty),
      .rdusedw     (rdusedw),
      .rdreq       (rdreq),
      .hsync       (hsync),
      .vsync       (vsync),
      .blank_n     (blank_n),
      .red         (red),
      .green       (green),
      .blue        (blue),
      .frame_start (frame_start),
      .underflow   (underflow)
   );

   always #5 clock = ~clock;

   typedef struct {
      int          cyc;
      logic        rdreq, hs, vs, bl, fs, uf;
      logic [23:0] rgb;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   cyc_cnt  = 0;

   // raster model state: position of the current cycle and registered values
   int   mh, mv, exp_n, prev_n, dut_n, dut_reads;
   bit   mrun, muf, prev_hs, prev_vs, prev_bl, prev_fs, prev_rd, dut_rd;

   always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

   function automatic void chk1(string name, logic act, logic exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s cycle %0d: got %b expected %b", name, cyc_cnt, act, exp);
   endfunction

   function automatic void chkv(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc_cnt, act, exp);
   endfunction

   // FIFO contents: word n; word 0 is A1B2C3
   function automatic logic [23:0] pat(int n);
      logic [23:0] base;
      base = 24'hA1B2C3;
      return base + 24'(n) * 24'h010101;
   endfunction

   task automatic model_reset();
      mh = 0; mv = 0; mrun = 1'b0; muf = 1'b0;
      prev_hs = 1'b1; prev_vs = 1'b1; prev_bl = 1'b0; prev_fs = 1'b0;
      prev_rd = 1'b0; prev_n = 0; dut_rd = 1'b0;
   endtask

   // Called at posedge+1: drive FIFO data, push this cycle's expectation, advance model
   task automatic cycle();
      exp_t e;
      bit   vis, rq;
      if (dut_rd) begin
         q = pat(dut_n);
         dut_n++;
      end else begin
         q = 24'h5A5A5A ^ 24'(cyc_cnt);
      end
      vis = (mh < HV) && (mv < VV);
      rq  = mrun && vis && !rdempty;
      e.cyc = cyc_cnt; e.rdreq = rq;
      e.hs = prev_hs; e.vs = prev_vs; e.bl = prev_bl; e.fs = prev_fs; e.uf = muf;
      e.rgb = prev_rd ? pat(prev_n) : 24'd0;
      sb.push_back(e);
      prev_hs = !((mh >= HV + HF) && (mh < HV + HF + HS));
      prev_vs = !((mv >= VV + VF) && (mv < VV + VF + VS));
      prev_bl = vis;
      prev_fs = (mh == 0) && (mv == 0);
      prev_rd = rq;
      prev_n  = exp_n;
      if (rq) exp_n++;
      if (mrun && vis && rdempty) muf = 1'b1;
      if (!mrun && mh == HT - 1 && mv == VT - 1 && rdusedw >= 10'd256) mrun = 1'b1;
      if (mh == HT - 1) begin
         mh = 0;
         mv = (mv == VT - 1) ? 0 : mv + 1;
      end else begin
         mh++;
      end
      @(negedge clock);
      dut_rd = rdreq;
      if (rdreq) dut_reads++;
      @(posedge clock);
      #1;
   endtask

   task automatic run_cycles(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic run_until(input int h, input int v);
      int budget = 0;
      while (!(mh == h && mv == v) && budget < 400) begin
         cycle();
         budget++;
      end
      chk1("reach_position", (mh == h) && (mv == v), 1'b1);
   endtask

   task automatic check_reset_vals();
      chk1("rst_hsync", hsync, 1'b1);
      chk1("rst_vsync", vsync, 1'b1);
      chk1("rst_blank_n", blank_n, 1'b0);
      chk1("rst_frame_start", frame_start, 1'b0);
      chk1("rst_underflow", underflow, 1'b0);
      chk1("rst_rdreq", rdreq, 1'b0);
      chkv("rst_rgb", {8'd0, red, green, blue}, 32'd0);
   endtask

   // Monitor: compare pins against the expectation tagged for this cycle
   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         if (sb.size() > 0 && sb[0].cyc == cyc_cnt) begin
            e = sb.pop_front();
            chk1("rdreq", rdreq, e.rdreq);
            chk1("hsync", hsync, e.hs);
            chk1("vsync", vsync, e.vs);
            chk1("blank_n", blank_n, e.bl);
            chk1("frame_start", frame_start, e.fs);
            chk1("underflow", underflow, e.uf);
            chkv("rgb", {8'd0, red, green, blue}, {8'd0, e.rgb});
         end
      end
   end

   // Stimulus
   initial begin
      int r0;
      exp_n = 0; dut_n = 0; dut_reads = 0;
      model_reset();
      #1 reset = 1'b1;
      @(posedge clock); @(posedge clock); #2;
      check_reset_vals();
      @(posedge clock); #1;
      reset = 1'b0;
      model_reset();

      // Empty FIFO: two frames of pure timing, no reads, black pixels
      run_cycles(2 * HT * VT);

      // FIFO fills mid-frame: reads must wait for the next (0,0)
      run_until(8, 4);
      rdusedw = 10'd300;
      rdempty = 1'b0;
      run_until(0, 0);
      r0 = dut_reads;
      run_cycles(HT * VT);
      chkv("reads_per_frame", dut_reads - r0, HV * VV);
      r0 = dut_reads;
      run_cycles(HT);
      chkv("reads_per_line", dut_reads - r0, HV);

      // Single-pixel underflow at (5,2)
      run_until(5, 2);
      rdempty = 1'b1;
      cycle();
      rdempty = 1'b0;
      run_cycles(HT * VT);

      // Asynchronous reset mid-frame at (10,3)
      run_until(10, 3);
      if (dut_rd) dut_n++;
      dut_rd = 1'b0;
      #3 reset = 1'b1;
      #2;
      check_reset_vals();
      @(posedge clock); @(posedge clock); #1;
      reset = 1'b0;
      model_reset();
      r0 = dut_reads;
      run_cycles(HT * VT);
      chkv("no_reads_in_wait_fill", dut_reads - r0, 0);
      run_cycles(2 * HT);

      @(negedge clock);
      #1;
      chkv("total_reads", dut_reads, exp_n);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
